hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, number of cycles a taken branch forces a decode bubble (legal 1..15).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum number of MEM_WAIT cycles before abort (legal 1..65535).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port id_rs1  in  5  source register 1 of the instruction in ID.
REQ-006 SHALL have port id_rs2  in  5  source register 2 of the instruction in ID.
REQ-007 SHALL have port id_use_rs1 / id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-008 SHALL have port ex_rd  in  5  destination register of the instruction in EX.
REQ-009 SHALL have port ex_reg_wr  in  1  EX instruction writes the register file.
REQ-010 SHALL have port ex_mem_reg  in  1  EX instruction is a load.
REQ-011 SHALL have port ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-012 SHALL have port mem_req / mem_ready  in  1 each  data-memory access pending / access completes this cycle.
REQ-013 SHALL have port pc_stall, if_id_stall, ex_hold  out  1 each  hold PC, hold IF/ID register, hold EX/MEM.
REQ-014 SHALL have port if_flush  out  1  squash the fetched instruction.
REQ-015 SHALL have port id_is_stall  out  2  decode bubble code: 00 none, 01 load-use bubble, 10 flush bubble.
REQ-016 SHALL have port mem_err  out  1  sticky memory-timeout flag.
REQ-017 SHALL have ports stall_cnt  out  32  (stall-cycle counter) and state  out  2  (current FSM state).

Function
REQ-018 SHALL implement FSM states RUN=0, FLUSH=1, MEM_WAIT=2; state 3 SHALL be unreachable and, if ever entered, SHALL return to RUN on the next edge.
REQ-019 SHALL evaluate all conditions in each cycle with fixed priority: memory wait > taken branch > load-use.
REQ-020 SHALL define the memory-wait condition as mem_req=1 and mem_ready=0.
REQ-021 SHALL define load-use as ex_mem_reg & ex_reg_wr & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-022 SHALL, in RUN with load-use only, assert pc_stall=1, if_id_stall=1 and id_is_stall=01 in the same cycle (combinational), remaining in RUN.
REQ-023 SHALL, in RUN with a taken branch, assert if_flush=1 and id_is_stall=10 in the same cycle; if FLUSH_CYCLES>1, it SHALL enter FLUSH with flush_cnt=FLUSH_CYCLES-1.
REQ-024 SHALL, in FLUSH, assert if_flush=1 and id_is_stall=10 and decrement flush_cnt each cycle, returning to RUN after the cycle in which flush_cnt=1.
REQ-025 SHALL ignore ex_branch_taken and load-use while in FLUSH.
REQ-026 SHALL, on the memory-wait condition in RUN or FLUSH, assert pc_stall=if_id_stall=ex_hold=1, if_flush=0 and id_is_stall=00 that cycle, enter MEM_WAIT, freeze flush_cnt and load wait_cnt=1.
REQ-027 SHALL, in MEM_WAIT, drive pc_stall=if_id_stall=ex_hold=!mem_ready, if_flush=0 and id_is_stall=00.
REQ-028 SHALL, in MEM_WAIT, increment wait_cnt each cycle while mem_ready=0.
REQ-029 SHALL exit MEM_WAIT on the edge after mem_ready=1, to FLUSH if flush_cnt!=0, else to RUN.
REQ-030 SHALL, when wait_cnt=MEM_TIMEOUT and mem_ready=0, set mem_err=1 and exit MEM_WAIT by the same rule as REQ-029.
REQ-031 SHALL clear mem_err only on reset.
REQ-032 SHALL increment stall_cnt on each cycle in which pc_stall=1, saturating at 0xFFFFFFFF.

Reset
REQ-033 SHALL, while rst=1, force state=RUN, flush_cnt=0, wait_cnt=0, mem_err=0 and stall_cnt=0.
REQ-034 SHALL, while rst=1, force all stall/flush outputs to 0 and id_is_stall=00.
REQ-035 SHALL, on reset asserted mid-FLUSH or mid-MEM_WAIT, abandon the operation immediately, with no residual bubble after release.

Verification
REQ-036 SHALL cover load-use: ex_mem_reg=1, ex_reg_wr=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> same cycle pc_stall=1, id_is_stall=01; the next cycle, with EX cleared, shows all 0; stall_cnt=1.
REQ-037 SHALL cover the x0 and unused-source cases: ex_rd=0 with id_rs1=0, and id_rs1=ex_rd=7 with id_use_rs1=0 -> no stall.
REQ-038 SHALL cover a taken branch with FLUSH_CYCLES=3: ex_branch_taken=1 for 1 cycle -> if_flush=1 and id_is_stall=10 for exactly 3 cycles, state 0,1,1,0.
REQ-039 SHALL cover branch-plus-load-use priority: ex_branch_taken=1 and load-use in the same cycle -> id_is_stall=10, pc_stall=0.
REQ-040 SHALL cover a memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> ex_hold=1 for 4 cycles, 0 on the ready cycle, state 2 then 0, stall_cnt=4.
REQ-041 SHALL cover timeout and reset: MEM_TIMEOUT=8 with mem_ready stuck at 0 -> mem_err=1 after cycle 8 and FSM returns to RUN; then rst=1 asserted mid-FLUSH -> all outputs 0 and mem_err=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline hazard signals exchanged between the pipeline datapath
// and the hazard controller.
//   ID stage   : id_rs1, id_rs2, id_use_rs1, id_use_rs2
//   EX stage   : ex_rd, ex_reg_wr, ex_mem_reg, ex_branch_taken
//   MEM stage  : mem_req, mem_ready
//   Controls   : pc_stall, if_id_stall, ex_hold, if_flush, id_is_stall[1:0]
//   Status     : mem_err, stall_cnt[31:0], state[1:0]
// master = pipeline side (drives stage info, consumes controls)
// slave  = hazard controller
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_wr;
  logic        ex_mem_reg;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        if_id_stall;
  logic        ex_hold;
  logic        if_flush;
  logic [1:0]  id_is_stall;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [1:0]  state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_wr,
           ex_mem_reg, ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, if_id_stall, ex_hold, if_flush, id_is_stall,
           mem_err, stall_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_wr,
           ex_mem_reg, ex_branch_taken, mem_req, mem_ready,
    output pc_stall, if_id_stall, ex_hold, if_flush, id_is_stall,
           mem_err, stall_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use bubbles, taken-branch flush bubbles and
// data-memory wait stalls with a timeout abort.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - hazard_ctrl_if.slave (stage info in, stall/flush controls and
//          status out)
// Parameters:
//   FLUSH_CYCLES - decode bubbles per taken branch (1..15)
//   MEM_TIMEOUT  - maximum MEM_WAIT cycles before abort (1..65535)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  localparam logic [3:0]  FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT     = 16'(MEM_TIMEOUT);
  localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        mem_wait_s;
  logic        load_use_s;
  logic        pc_stall_s;
  logic        if_id_stall_s;
  logic        ex_hold_s;
  logic        if_flush_s;
  logic [1:0]  id_is_stall_s;

  assign mem_wait_s = bus.mem_req & ~bus.mem_ready;
  assign load_use_s = bus.ex_mem_reg & bus.ex_reg_wr & (bus.ex_rd != 5'd0) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Next-state and combinational control outputs; priority mem wait > branch > load-use.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    pc_stall_s    = 1'b0;
    if_id_stall_s = 1'b0;
    ex_hold_s     = 1'b0;
    if_flush_s    = 1'b0;
    id_is_stall_s = 2'b00;
    case (state_q)
      RUN: begin
        if (mem_wait_s) begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          ex_hold_s     = 1'b1;
          wait_cnt_d    = 16'd1;
          state_d       = MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
          if_flush_s    = 1'b1;
          id_is_stall_s = 2'b10;
          if (MULTI_FLUSH) begin
            flush_cnt_d = FLUSH_INIT;
            state_d     = FLUSH;
          end else begin
            flush_cnt_d = 4'd0;
          end
        end else if (load_use_s) begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          id_is_stall_s = 2'b01;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // flush_cnt is left untouched on a memory wait so the remaining
        // bubbles resume once memory completes.
        if (mem_wait_s) begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          ex_hold_s     = 1'b1;
          wait_cnt_d    = 16'd1;
          state_d       = MEM_WAIT;
        end else begin
          if_flush_s    = 1'b1;
          id_is_stall_s = 2'b10;
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = 4'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
      end
      MEM_WAIT: begin
        pc_stall_s    = ~bus.mem_ready;
        if_id_stall_s = ~bus.mem_ready;
        ex_hold_s     = ~bus.mem_ready;
        if (bus.mem_ready || (wait_cnt_q >= TIMEOUT)) begin
          if (!bus.mem_ready) begin
            mem_err_d = 1'b1;
          end else begin
            mem_err_d = mem_err_q;
          end
          if (flush_cnt_q != 4'd0) begin
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stall-cycle counter, saturating.
  always_comb begin
    if (pc_stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 4'd0;
      wait_cnt_q  <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are forced quiet while reset is held, independent of inputs.
  always_comb begin
    if (rst) begin
      bus.pc_stall    = 1'b0;
      bus.if_id_stall = 1'b0;
      bus.ex_hold     = 1'b0;
      bus.if_flush    = 1'b0;
      bus.id_is_stall = 2'b00;
    end else begin
      bus.pc_stall    = pc_stall_s;
      bus.if_id_stall = if_id_stall_s;
      bus.ex_hold     = ex_hold_s;
      bus.if_flush    = if_flush_s;
      bus.id_is_stall = id_is_stall_s;
    end
  end

  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected output vectors are queued when a cycle is driven and
// popped when the cycle is sampled.
// Output vector: {pc_stall, if_id_stall, ex_hold, if_flush, id_is_stall[1:0],
//                 state[1:0]}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ml;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [7:0] sb[$];

  hazard_ctrl_if bus();

  hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic wr, input logic ml, input logic br,
                             input logic req, input logic rdy);
    in_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.wr = wr; s.ml = ml; s.br = br; s.req = req; s.rdy = rdy;
    return s;
  endfunction

  function automatic logic [7:0] obs();
    return {bus.pc_stall, bus.if_id_stall, bus.ex_hold, bus.if_flush,
            bus.id_is_stall, bus.state};
  endfunction

  task automatic drive(input in_t s);
    bus.id_rs1          = s.rs1;
    bus.id_rs2          = s.rs2;
    bus.id_use_rs1      = s.u1;
    bus.id_use_rs2      = s.u2;
    bus.ex_rd           = s.rd;
    bus.ex_reg_wr       = s.wr;
    bus.ex_mem_reg      = s.ml;
    bus.ex_branch_taken = s.br;
    bus.mem_req         = s.req;
    bus.mem_ready       = s.rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reset with every hazard input active: controls stay quiet, status cleared.
  task automatic test_reset();
    rst = 1'b1;
    drive(mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (obs() !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), 8'h00);
    end
    tests_run++;
    if (bus.stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
    tests_run++;
    if (bus.mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mem_err: got %b expected 0", bus.mem_err);
    end
    rst = 1'b0;
    drive('0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    in_t st[$];
    logic [7:0] ex[$];
    logic [7:0] e;
    do_reset();
    st.push_back(mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'hC4);
    st.push_back('0);                                                             ex.push_back(8'h00);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, obs(), e);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.stall_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL load_use_stall_cnt: got %0d expected 1", bus.stall_cnt);
    end
  endtask

  task automatic test_no_stall();
    in_t st[$];
    logic [7:0] ex[$];
    logic [7:0] e;
    do_reset();
    st.push_back(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'h00);
    st.push_back(mk(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'h00);
    st.push_back(mk(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'h00);
    st.push_back(mk(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(8'h00);
    st.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)); ex.push_back(8'h00);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL no_stall[%0d]: got %h expected %h", i, obs(), e);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL no_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
  endtask

  // Taken branch: three flush bubbles; branch and load-use ignored inside FLUSH.
  task automatic test_branch();
    in_t st[$];
    logic [7:0] ex[$];
    logic [7:0] e;
    do_reset();
    st.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); ex.push_back(8'h18);
    st.push_back(mk(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'h19);
    st.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); ex.push_back(8'h19);
    st.push_back('0);                                                             ex.push_back(8'h00);
    st.push_back('0);                                                             ex.push_back(8'h00);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs(), e);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL branch_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
  endtask

  // Branch beats load-use in the same cycle.
  task automatic test_priority();
    in_t st[$];
    logic [7:0] ex[$];
    logic [7:0] e;
    do_reset();
    st.push_back(mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'hC4);
    st.push_back(mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)); ex.push_back(8'h18);
    st.push_back(mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(8'h19);
    st.push_back('0);                                                             ex.push_back(8'h19);
    st.push_back('0);                                                             ex.push_back(8'h00);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL priority[%0d]: got %h expected %h", i, obs(), e);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.stall_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL priority_stall_cnt: got %0d expected 1", bus.stall_cnt);
    end
  endtask

  // Memory wait from RUN, from FLUSH (flush resumes), and beating a branch.
  task automatic test_mem_wait();
    in_t st[$];
    logic [7:0] ex[$];
    logic [7:0] e;
    in_t mw;
    in_t rdy;
    mw  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rdy = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    do_reset();
    st.push_back(mw);  ex.push_back(8'hE0);
    st.push_back(mw);  ex.push_back(8'hE2);
    st.push_back(mw);  ex.push_back(8'hE2);
    st.push_back(mw);  ex.push_back(8'hE2);
    st.push_back(rdy); ex.push_back(8'h02);
    st.push_back('0);  ex.push_back(8'h00);
    st.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); ex.push_back(8'h18);
    st.push_back(mw);  ex.push_back(8'hE1);
    st.push_back(mw);  ex.push_back(8'hE2);
    st.push_back(rdy); ex.push_back(8'h02);
    st.push_back('0);  ex.push_back(8'h19);
    st.push_back('0);  ex.push_back(8'h19);
    st.push_back('0);  ex.push_back(8'h00);
    st.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ex.push_back(8'hE0);
    st.push_back(rdy); ex.push_back(8'h02);
    st.push_back('0);  ex.push_back(8'h00);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL mem_wait[%0d]: got %h expected %h", i, obs(), e);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bus.stall_cnt !== 32'd7) begin
      tests_failed++;
      $display("FAIL mem_wait_stall_cnt: got %0d expected 7", bus.stall_cnt);
    end
  endtask

  // Timeout after 8 MEM_WAIT cycles, then reset mid-FLUSH.
  task automatic test_timeout_reset();
    logic [7:0] e;
    in_t mw;
    mw = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(mw);
      sb.push_back((i == 0) ? 8'hE0 : 8'hE2);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ((obs() !== e) || (bus.mem_err !== 1'b0)) begin
        tests_failed++;
        $display("FAIL timeout[%0d]: got %h err %b expected %h err 0", i, obs(), bus.mem_err, e);
      end
      @(posedge clk);
      #1;
    end
    drive('0);
    #1;
    tests_run++;
    if ((obs() !== 8'h00) || (bus.mem_err !== 1'b1) || (bus.stall_cnt !== 32'd9)) begin
      tests_failed++;
      $display("FAIL timeout_abort: got %h err %b cnt %0d expected 00 err 1 cnt 9",
               obs(), bus.mem_err, bus.stall_cnt);
    end
    @(posedge clk);
    #1;
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    #1;
    tests_run++;
    if (obs() !== 8'h18) begin
      tests_failed++;
      $display("FAIL timeout_branch: got %h expected 18", obs());
    end
    @(posedge clk);
    #1;
    drive('0);
    #1;
    tests_run++;
    if (obs() !== 8'h19) begin
      tests_failed++;
      $display("FAIL in_flush: got %h expected 19", obs());
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ((obs() !== 8'h00) || (bus.mem_err !== 1'b0) || (bus.stall_cnt !== 32'd0)) begin
      tests_failed++;
      $display("FAIL reset_mid_flush: got %h err %b cnt %0d expected 00 err 0 cnt 0",
               obs(), bus.mem_err, bus.stall_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      sb.push_back(8'h00);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (obs() !== e) begin
        tests_failed++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive('0);
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_priority();
    test_mem_wait();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
